// File: rtl/rtc_poll_scheduler.sv
// Command sequencer for a DS1302 driver: clears write-protect, polls the time
// registers, publishes an untorn BCD time and services user set-time requests.
module rtc_poll_scheduler #(
    parameter logic [23:0] POLL_CYCLES    = 24'd5_000_000,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd200_000
) (
    input  logic       CLK,
    input  logic       RSTn,
    output logic [7:0] Start_Sig,
    input  logic       Done_Sig,
    output logic [7:0] Time_Write_Data,
    input  logic [7:0] Time_Read_Data,
    input  logic       Set_Req,
    input  logic [7:0] Set_Hour,
    input  logic [7:0] Set_Min,
    input  logic [7:0] Set_Sec,
    output logic       Set_Busy,
    output logic [7:0] Hour,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic       Time_Valid,
    output logic       Time_Update,
    output logic       Rtc_Err
);

    typedef enum logic [3:0] {
        S_INIT_WP, S_RD_SEC, S_RD_MIN, S_RD_HOUR, S_COMMIT, S_WAIT,
        S_SET_WP, S_WR_HOUR, S_WR_MIN, S_WR_SEC, S_GAP
    } state_t;

    state_t      state_q, state_d, ret_q, ret_d;
    logic [7:0]  start_q, start_d, wdata_q, wdata_d;
    logic [19:0] tmr_q, tmr_d;
    logic [23:0] poll_q, poll_d;
    logic [7:0]  sec_sh_q, sec_sh_d, min_sh_q, min_sh_d, hour_sh_q, hour_sh_d;
    logic [7:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]  set_sec_q, set_sec_d, set_min_q, set_min_d, set_hour_q, set_hour_d;
    logic        busy_q, busy_d, valid_q, valid_d, upd_q, upd_d, err_q, err_d;
    logic        issue;
    state_t      issue_st;

    function automatic logic [7:0] cmd_of(input state_t s);
        case (s)
            S_INIT_WP, S_SET_WP: cmd_of = 8'h80;
            S_WR_HOUR:           cmd_of = 8'h40;
            S_WR_MIN:            cmd_of = 8'h20;
            S_WR_SEC:            cmd_of = 8'h10;
            S_RD_HOUR:           cmd_of = 8'h04;
            S_RD_MIN:            cmd_of = 8'h02;
            S_RD_SEC:            cmd_of = 8'h01;
            default:             cmd_of = 8'h00;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            S_RD_SEC:  next_of = S_RD_MIN;
            S_RD_MIN:  next_of = S_RD_HOUR;
            S_RD_HOUR: next_of = S_COMMIT;
            S_SET_WP:  next_of = S_WR_HOUR;
            S_WR_HOUR: next_of = S_WR_MIN;
            S_WR_MIN:  next_of = S_WR_SEC;
            default:   next_of = S_RD_SEC;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_INIT_WP;
            ret_q      <= S_RD_SEC;
            start_q    <= 8'h00;
            wdata_q    <= 8'h00;
            tmr_q      <= 20'd0;
            poll_q     <= 24'd0;
            sec_sh_q   <= 8'h00;
            min_sh_q   <= 8'h00;
            hour_sh_q  <= 8'h00;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hour_q     <= 8'h00;
            set_sec_q  <= 8'h00;
            set_min_q  <= 8'h00;
            set_hour_q <= 8'h00;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            start_q    <= start_d;
            wdata_q    <= wdata_d;
            tmr_q      <= tmr_d;
            poll_q     <= poll_d;
            sec_sh_q   <= sec_sh_d;
            min_sh_q   <= min_sh_d;
            hour_sh_q  <= hour_sh_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            set_sec_q  <= set_sec_d;
            set_min_q  <= set_min_d;
            set_hour_q <= set_hour_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        start_d    = start_q;
        wdata_d    = wdata_q;
        tmr_d      = tmr_q;
        poll_d     = poll_q;
        sec_sh_d   = sec_sh_q;
        min_sh_d   = min_sh_q;
        hour_sh_d  = hour_sh_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        set_sec_d  = set_sec_q;
        set_min_d  = set_min_q;
        set_hour_d = set_hour_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        upd_d      = 1'b0;
        err_d      = err_q;
        issue      = 1'b0;
        issue_st   = state_q;

        if (Set_Req && !busy_q) begin
            busy_d     = 1'b1;
            set_sec_d  = Set_Sec;
            set_min_d  = Set_Min;
            set_hour_d = Set_Hour;
        end

        case (state_q)
            S_GAP: begin
                state_d = ret_q;
                if (ret_q != S_COMMIT) begin
                    issue    = 1'b1;
                    issue_st = ret_q;
                end
            end
            S_COMMIT: begin
                sec_d   = sec_sh_q;
                min_d   = min_sh_q;
                hour_d  = hour_sh_q;
                upd_d   = 1'b1;
                valid_d = 1'b1;
                poll_d  = 24'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A pending set pre-empts the poll wait; otherwise the next burst
                // starts POLL_CYCLES clocks after COMMIT.
                if (busy_q) begin
                    state_d  = S_SET_WP;
                    issue    = 1'b1;
                    issue_st = S_SET_WP;
                end else if (poll_q >= POLL_CYCLES - 24'd1) begin
                    state_d  = S_RD_SEC;
                    issue    = 1'b1;
                    issue_st = S_RD_SEC;
                end else begin
                    poll_d = poll_q + 24'd1;
                end
            end
            default: begin
                // Start_Sig is only idle in a command state right after reset.
                if (start_q == 8'h00) begin
                    issue    = 1'b1;
                    issue_st = state_q;
                end else if (Done_Sig || (tmr_q == TIMEOUT_CYCLES - 20'd1)) begin
                    start_d = 8'h00;
                    wdata_d = 8'h00;
                    state_d = S_GAP;
                    ret_d   = next_of(state_q);
                    if (!Done_Sig) begin
                        err_d = 1'b1;
                    end else begin
                        case (state_q)
                            S_RD_SEC:  sec_sh_d  = Time_Read_Data & 8'h7F;
                            S_RD_MIN:  min_sh_d  = Time_Read_Data & 8'h7F;
                            S_RD_HOUR: hour_sh_d = Time_Read_Data & 8'h3F;
                            default:   ;
                        endcase
                    end
                    if (state_q == S_WR_SEC) begin
                        busy_d = 1'b0;
                    end
                end else begin
                    tmr_d = tmr_q + 20'd1;
                end
            end
        endcase

        if (issue) begin
            start_d = cmd_of(issue_st);
            tmr_d   = 20'd0;
            case (issue_st)
                S_WR_HOUR: wdata_d = set_hour_q & 8'h3F;
                S_WR_MIN:  wdata_d = set_min_q;
                S_WR_SEC:  wdata_d = set_sec_q & 8'h7F;
                default:   wdata_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        Start_Sig       = start_q;
        Time_Write_Data = wdata_q;
        Set_Busy        = busy_q;
        Hour            = hour_q;
        Min             = min_q;
        Sec             = sec_q;
        Time_Valid      = valid_q;
        Time_Update     = upd_q;
        Rtc_Err         = err_q;
    end

endmodule

// File: tb/tb_rtc_poll_scheduler.sv
// Bench for rtc_poll_scheduler: a DS1302 stand-in answers commands, a scoreboard
// checks the command stream, and read vectors check the published time.
module tb_rtc_poll_scheduler;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b1;
    logic [7:0] Start_Sig;
    logic       Done_Sig = 1'b0;
    logic [7:0] Time_Write_Data;
    logic [7:0] Time_Read_Data = 8'hEE;
    logic       Set_Req = 1'b0;
    logic [7:0] Set_Hour = 8'h00, Set_Min = 8'h00, Set_Sec = 8'h00;
    logic       Set_Busy;
    logic [7:0] Hour, Min, Sec;
    logic       Time_Valid, Time_Update, Rtc_Err;

    always #5 CLK = ~CLK;

    rtc_poll_scheduler #(
        .POLL_CYCLES   (24'd100),
        .TIMEOUT_CYCLES(20'd50)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Start_Sig      (Start_Sig),
        .Done_Sig       (Done_Sig),
        .Time_Write_Data(Time_Write_Data),
        .Time_Read_Data (Time_Read_Data),
        .Set_Req        (Set_Req),
        .Set_Hour       (Set_Hour),
        .Set_Min        (Set_Min),
        .Set_Sec        (Set_Sec),
        .Set_Busy       (Set_Busy),
        .Hour           (Hour),
        .Min            (Min),
        .Sec            (Sec),
        .Time_Valid     (Time_Valid),
        .Time_Update    (Time_Update),
        .Rtc_Err        (Rtc_Err)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        bit         gap_chk;
    } exp_cmd_t;

    typedef struct {
        logic [7:0] sec_raw, min_raw, hour_raw;
        logic [7:0] exp_sec, exp_min, exp_hour;
    } vec_t;

    exp_cmd_t    exp_q[$];
    vec_t        vecs[4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cnt = 0;
    int          zero_run = 0;
    int          upd_cyc;
    int          n;
    logic [7:0]  prev_start = 8'h00;
    logic [23:0] last_time = 24'h0;
    logic [7:0]  rtc_sec = 8'h00, rtc_min = 8'h00, rtc_hour = 8'h00;
    logic [7:0]  withhold = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] d, input bit g);
        exp_cmd_t e;
        e.cmd = c;
        e.data = d;
        e.gap_chk = g;
        exp_q.push_back(e);
    endtask

    // One clock: the DS1302 stand-in, the command scoreboard and the no-tear check
    // all run #1 after the rising edge.
    task automatic tick();
        exp_cmd_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (Start_Sig != 8'h00 && Start_Sig != prev_start) begin
            $display("cmd %02h data %02h at cycle %0d", Start_Sig, Time_Write_Data, cyc);
            check("onehot", $countones(Start_Sig), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cmd", Start_Sig, e.cmd);
                check("wdata", Time_Write_Data, e.data);
                if (e.gap_chk) check("gap", zero_run, 1);
            end
        end
        zero_run = (Start_Sig == 8'h00) ? zero_run + 1 : 0;
        if (Start_Sig == 8'h00) cnt = 0;
        else if (Start_Sig == prev_start) cnt++;
        else cnt = 1;
        Done_Sig = 1'b0;
        Time_Read_Data = 8'hEE;
        if (cnt == 3 && (Start_Sig & withhold) == 8'h00) begin
            Done_Sig = 1'b1;
            case (Start_Sig)
                8'h01: Time_Read_Data = rtc_sec;
                8'h02: Time_Read_Data = rtc_min;
                8'h04: Time_Read_Data = rtc_hour;
                8'h40: rtc_hour = Time_Write_Data;
                8'h20: rtc_min = Time_Write_Data;
                8'h10: rtc_sec = Time_Write_Data;
                default: ;
            endcase
        end
        prev_start = Start_Sig;
        if (RSTn && {Hour, Min, Sec} != last_time) check("no_tear", Time_Update, 1);
        last_time = {Hour, Min, Sec};
    endtask

    task automatic wait_cmd(input logic [7:0] c, input int lim, input string nm);
        int k = 0;
        while (Start_Sig !== c && k < lim) begin
            tick();
            k++;
        end
        check(nm, Start_Sig, c);
    endtask

    task automatic wait_update(input int lim, input string nm);
        int k = 0;
        while (Time_Update !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        check(nm, Time_Update, 1);
    endtask

    initial begin
        vecs[0] = '{8'h85, 8'h59, 8'h23, 8'h05, 8'h59, 8'h23};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h3F};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h47, 8'hC8, 8'h92, 8'h47, 8'h48, 8'h12};

        #2 RSTn = 1'b0;
        repeat (3) tick();
        check("rst_start", Start_Sig, 8'h00);
        check("rst_wdata", Time_Write_Data, 8'h00);
        check("rst_time", {Hour, Min, Sec}, 24'h0);
        check("rst_flags", {Set_Busy, Time_Valid, Time_Update, Rtc_Err}, 4'b0000);

        rtc_sec = vecs[0].sec_raw;
        rtc_min = vecs[0].min_raw;
        rtc_hour = vecs[0].hour_raw;
        push(8'h80, 8'h00, 1'b0);
        push(8'h01, 8'h00, 1'b1);
        push(8'h02, 8'h00, 1'b1);
        push(8'h04, 8'h00, 1'b1);
        RSTn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                rtc_sec = vecs[i].sec_raw;
                rtc_min = vecs[i].min_raw;
                rtc_hour = vecs[i].hour_raw;
                push(8'h01, 8'h00, 1'b0);
                push(8'h02, 8'h00, 1'b1);
                push(8'h04, 8'h00, 1'b1);
                wait_cmd(8'h01, 300, "poll_start");
                check("poll_interval", cyc - upd_cyc, 99);
            end
            wait_update(300, "update");
            upd_cyc = cyc;
            check("vec_sec", Sec, vecs[i].exp_sec);
            check("vec_min", Min, vecs[i].exp_min);
            check("vec_hour", Hour, vecs[i].exp_hour);
            check("valid", {Time_Valid, Rtc_Err}, 2'b10);
            check("sb_drain", exp_q.size(), 0);
            tick();
            check("update_pulse", Time_Update, 0);
        end

        // Set request arriving during a read burst, then a second one while busy.
        wait_cmd(8'h01, 300, "burst_start");
        push(8'h02, 8'h00, 1'b1);
        push(8'h04, 8'h00, 1'b1);
        push(8'h80, 8'h00, 1'b0);
        push(8'h40, 8'h12, 1'b1);
        push(8'h20, 8'h34, 1'b1);
        push(8'h10, 8'h56, 1'b1);
        push(8'h01, 8'h00, 1'b1);
        Set_Req = 1'b1; Set_Hour = 8'h12; Set_Min = 8'h34; Set_Sec = 8'h56;
        tick();
        Set_Req = 1'b0;
        check("busy_set", Set_Busy, 1);
        Set_Req = 1'b1; Set_Hour = 8'h99; Set_Min = 8'h88; Set_Sec = 8'h77;
        tick();
        Set_Req = 1'b0;
        wait_cmd(8'h10, 400, "wr_sec");
        check("busy_during_wr", Set_Busy, 1);
        wait_cmd(8'h01, 50, "readback_start");
        check("busy_clear", Set_Busy, 0);
        wait_update(100, "readback_update");
        check("set_time", {Hour, Min, Sec}, 24'h123456);
        check("sb_drain_set", exp_q.size(), 0);

        // Withheld Done_Sig on the minute read.
        rtc_sec = 8'h11; rtc_min = 8'h22; rtc_hour = 8'h09;
        withhold = 8'h02;
        push(8'h01, 8'h00, 1'b0);
        push(8'h02, 8'h00, 1'b1);
        push(8'h04, 8'h00, 1'b1);
        wait_cmd(8'h02, 300, "rd_min");
        check("err_before", Rtc_Err, 0);
        n = 0;
        while (Start_Sig == 8'h02 && n < 200) begin
            tick();
            n++;
        end
        check("timeout_len", n, 50);
        check("err_set", Rtc_Err, 1);
        wait_update(100, "timeout_update");
        check("timeout_time", {Hour, Min, Sec}, 24'h093411);
        withhold = 8'h00;
        push(8'h01, 8'h00, 1'b0);
        push(8'h02, 8'h00, 1'b1);
        push(8'h04, 8'h00, 1'b1);
        tick();
        wait_update(300, "recover_update");
        check("recover_time", {Hour, Min, Sec}, 24'h092211);
        check("err_sticky", Rtc_Err, 1);
        check("sb_drain_to", exp_q.size(), 0);

        // Reset in the middle of the hour write.
        Set_Req = 1'b1; Set_Hour = 8'h01; Set_Min = 8'h02; Set_Sec = 8'h03;
        tick();
        Set_Req = 1'b0;
        wait_cmd(8'h40, 300, "wr_hour");
        RSTn = 1'b0;
        #1;
        check("arst_start", Start_Sig, 8'h00);
        check("arst_wdata", Time_Write_Data, 8'h00);
        check("arst_time", {Hour, Min, Sec}, 24'h0);
        check("arst_flags", {Set_Busy, Time_Valid, Time_Update, Rtc_Err}, 4'b0000);
        exp_q.delete();
        push(8'h80, 8'h00, 1'b0);
        push(8'h01, 8'h00, 1'b1);
        push(8'h02, 8'h00, 1'b1);
        push(8'h04, 8'h00, 1'b1);
        repeat (3) tick();
        RSTn = 1'b1;
        wait_update(100, "post_rst_update");
        check("post_rst_time", {Hour, Min, Sec}, 24'h092211);
        check("post_rst_flags", {Set_Busy, Time_Valid, Rtc_Err}, 3'b010);
        check("sb_drain_rst", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_poll_scheduler.md
Name: rtc_poll_scheduler

Overview:
- Command sequencer in front of ds1302_module; drives its one-hot Start_Sig/Done_Sig command port.
- After reset, clears write-protect, then reads seconds/minutes/hours every POLL_CYCLES clocks.
- Presents an atomically updated BCD time to the display/UART logic.
- Accepts a user set-time request and writes hour/minute/second to the DS1302 between polls.

Parameters:
- POLL_CYCLES, 24'd5_000_000: clocks from the end of one read burst to the start of the next (100 ms at 50 MHz).
- TIMEOUT_CYCLES, 20'd200_000: maximum clocks to wait for Done_Sig per command before aborting.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  asynchronous active-low reset.
- Start_Sig  output  8  one-hot command to ds1302_module; encoding below.
- Done_Sig  input  1  one-cycle completion pulse from ds1302_module.
- Time_Write_Data  output  8  BCD data for write commands.
- Time_Read_Data  input  8  register data; valid in the cycle Done_Sig is high on a read.
- Set_Req  input  1  one-cycle pulse requesting a time set.
- Set_Hour  input  8  BCD hour, 00-23; sampled on Set_Req.
- Set_Min  input  8  BCD minute; sampled on Set_Req.
- Set_Sec  input  8  BCD second; sampled on Set_Req.
- Set_Busy  output  1  high from the accepted Set_Req until the last set write completes.
- Hour  output  8  BCD hours, 24 h mode.
- Min  output  8  BCD minutes.
- Sec  output  8  BCD seconds, CH bit stripped.
- Time_Valid  output  1  high after the first complete read burst.
- Time_Update  output  1  one-cycle pulse when Hour/Min/Sec commit.
- Rtc_Err  output  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Start_Sig encoding:
  - [7] write-protect off (0x00 to reg 0x8E).
  - [6] write hour; [5] write minute; [4] write second.
  - [3] reserved, never asserted.
  - [2] read hour; [1] read minute; [0] read second.
- At most one Start_Sig bit is high at any time.
- Reset values: Start_Sig=0, Time_Write_Data=0, Hour/Min/Sec=8'h00, Set_Busy=0, Time_Valid=0, Time_Update=0, Rtc_Err=0. FSM enters INIT_WP.
- Command handshake:
  - FSM asserts its bit and holds Start_Sig and Time_Write_Data stable until Done_Sig is sampled high.
  - In that same edge Start_Sig goes to 0 and the FSM enters GAP for exactly 1 cycle; the next command starts after GAP.
  - Done_Sig while Start_Sig=0 is ignored.
- Timeout: a per-command counter clears at command start. When it reaches TIMEOUT_CYCLES:
  - Start_Sig drops, Rtc_Err sets, the command is treated as done.
  - Read data is discarded and the shadow register is unchanged.
  - The sequence continues.
- States and transitions:
  - INIT_WP: cmd[7] -> GAP -> RD_SEC.
  - RD_SEC -> RD_MIN -> RD_HOUR (each through GAP) -> COMMIT.
  - COMMIT (1 cycle): copy shadows to Hour/Min/Sec, pulse Time_Update, set Time_Valid; load poll counter -> WAIT.
  - WAIT: counts POLL_CYCLES. Goes to SET_WP if a set is pending, else to RD_SEC when the count expires.
  - SET_WP cmd[7] -> WR_HOUR cmd[6] -> WR_MIN cmd[5] -> WR_SEC cmd[4] (each through GAP).
  - After WR_SEC completes: Set_Busy clears, then RD_SEC immediately (no WAIT), so the new time reads back.
- Read masking:
  - Sec shadow = Time_Read_Data & 8'h7F.
  - Min shadow = Time_Read_Data & 8'h7F.
  - Hour shadow = Time_Read_Data & 8'h3F.
  - Hour/Min/Sec never change outside COMMIT, so the outputs are never torn.
  - A timed-out read keeps the previous shadow value; COMMIT still occurs.
- Set request acceptance:
  - Set_Req with Set_Busy=0: latch the three values, Set_Busy=1 next cycle. Service starts at the next WAIT (a read burst in progress finishes first).
  - Set_Req with Set_Busy=1: ignored.
  - Set_Req during INIT_WP: accepted and serviced after the first COMMIT.
- Write data:
  - WR_SEC writes Set_Sec & 8'h7F (CH=0, oscillator running).
  - WR_HOUR writes Set_Hour & 8'h3F (24 h mode).
  - No BCD range checking.
- Reset mid-command: Start_Sig drops asynchronously; after release the sequence restarts at INIT_WP.

Test Plan:
- Reset release, model answers Done_Sig 3 cycles after each start, reads return 8'h85/8'h59/8'h23 -> Start_Sig sequence 80,01,02,04 with 1-cycle zero gaps; then Sec=85&7F=8'h05, Min=8'h59, Hour=8'h23; one Time_Update pulse; Time_Valid=1.
- POLL_CYCLES=100, model read values change -> next burst starts 100 cycles after COMMIT; outputs update only on the Time_Update cycle.
- Set_Req with 8'h12/8'h34/8'h56 during a read burst -> burst completes, then after WAIT: 80,40(data 12),20(data 34),10(data 56); Set_Busy drops after cmd 10 done; RD_SEC follows immediately.
- Second Set_Req while Set_Busy=1 with different data -> ignored; the first values are written.
- Model withholds Done_Sig on RD_MIN, TIMEOUT_CYCLES=50 -> Start_Sig=02 drops at cycle 50; Rtc_Err=1 and stays set; Min holds its previous value; RD_HOUR proceeds.
- Assert RSTn low while Start_Sig=40 -> all outputs return to reset values immediately; after release, cmd 80 is issued first.
